vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counter with registered coordinate and sync/visible decode.
// Flags are decoded from the next counter value so they line up with x/y in the same cycle.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          H_POL     = 1'b0,
    parameter bit          V_POL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       h_sync,
    output logic       v_sync,
    output logic       frame_active,
    output logic       line_end,
    output logic       frame_end
);

    localparam int unsigned CW      = 10;
    localparam int unsigned EW      = CW + 1;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Last counter values before wrap.
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Decode boundaries are one bit wider so an end value of 1024 stays representable.
    localparam logic [EW-1:0] H_VIS_END  = EW'(H_VISIBLE);
    localparam logic [EW-1:0] H_SYNC_BEG = EW'(H_VISIBLE + H_FRONT);
    localparam logic [EW-1:0] H_SYNC_END = EW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [EW-1:0] V_VIS_END  = EW'(V_VISIBLE);
    localparam logic [EW-1:0] V_SYNC_BEG = EW'(V_VISIBLE + V_FRONT);
    localparam logic [EW-1:0] V_SYNC_END = EW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          frame_active_q, frame_active_d;
    logic          line_end_q, line_end_d;
    logic          frame_end_q, frame_end_d;

    logic [EW-1:0] x_ext;
    logic [EW-1:0] y_ext;
    logic          h_act;
    logic          v_act;

    // Next position and the flags that belong to it; everything holds while en is low.
    always_comb begin
        x_d            = x_q;
        y_d            = y_q;
        h_sync_d       = h_sync_q;
        v_sync_d       = v_sync_q;
        frame_active_d = frame_active_q;
        line_end_d     = line_end_q;
        frame_end_d    = frame_end_q;
        x_ext          = '0;
        y_ext          = '0;
        h_act          = 1'b0;
        v_act          = 1'b0;

        if (en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + CW'(1);
                end
            end else begin
                x_d = x_q + CW'(1);
            end

            x_ext          = {1'b0, x_d};
            y_ext          = {1'b0, y_d};
            h_act          = (x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END);
            v_act          = (y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END);
            frame_active_d = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
            h_sync_d       = h_act ? H_POL : ~H_POL;
            v_sync_d       = v_act ? V_POL : ~V_POL;
            line_end_d     = (x_d == H_LAST);
            frame_end_d    = (x_d == H_LAST) && (y_d == V_LAST);
        end
    end

    // State register with synchronous reset to the top-left pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q            <= '0;
            y_q            <= '0;
            h_sync_q       <= ~H_POL;
            v_sync_q       <= ~V_POL;
            frame_active_q <= 1'b1;
            line_end_q     <= 1'b0;
            frame_end_q    <= 1'b0;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            h_sync_q       <= h_sync_d;
            v_sync_q       <= v_sync_d;
            frame_active_q <= frame_active_d;
            line_end_q     <= line_end_d;
            frame_end_q    <= frame_end_d;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign h_sync       = h_sync_q;
    assign v_sync       = v_sync_q;
    assign frame_active = frame_active_q;
    assign line_end     = line_end_q;
    assign frame_end    = frame_end_q;

endmodule
